btn_cmd_scheduler: RTL and testbench

- Sits between the 4-button debouncer's level outputs and the accelerometer command executor (SPI command FSM).
- Converts debounced button presses into one-shot commands and queues them in a small FIFO.
- Issues one command at a time to the executor over a valid/ready handshake, then waits for completion with a timeout.
- Enforces a minimum idle gap between consecutive commands.

---
 rtl/btn_cmd_scheduler_pkg.sv | 28 ++
 rtl/btn_cmd_scheduler_fifo.sv | 45 ++++
 rtl/btn_cmd_scheduler.sv | 106 ++++++++++
 tb/tb_btn_cmd_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_cmd_scheduler_pkg.sv
// btn_cmd_pkg: shared state encodings, command codes and cycle-count helpers for the button command scheduler.
package btn_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam logic [1:0] CMD_BTN0 = 2'd0;
  localparam logic [1:0] CMD_BTN1 = 2'd1;
  localparam logic [1:0] CMD_BTN2 = 2'd2;
  localparam logic [1:0] CMD_BTN3 = 2'd3;

  function automatic int cycles(input int fclk, input int per_sec, input int n);
    return fclk / per_sec * n;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_cmd_scheduler_fifo.sv
// cmd_fifo: single-clock first-word-fall-through FIFO; a push into a full FIFO is taken when a pop frees a slot on the same edge.
module cmd_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_dout  = mem_q[rd_q];
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);
  assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q  <= do_pop ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q] <= i_din;
  end

endmodule

// File: rtl/btn_cmd_scheduler.sv
// btn_cmd_scheduler: turns debounced button rises into queued one-shot commands and issues them one at a time
// over valid/ready, waiting for done (with timeout) and a minimum gap before the next command.
module btn_cmd_scheduler
  import btn_cmd_pkg::*;
#(
  parameter int FCLK       = 20000000,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_US     = 50,
  parameter int TIMEOUT_MS = 10
) (
  input  logic       i_clk_mhz,
  input  logic       i_rst_mhz_n,
  input  logic [3:0] i_btns_deb,
  output logic       o_cmd_valid,
  output logic [1:0] o_cmd_code,
  input  logic       i_cmd_ready,
  input  logic       i_cmd_done,
  output logic       o_busy,
  output logic       o_drop_pulse,
  output logic       o_err_timeout,
  output logic [1:0] o_mode
);
  localparam int C_GAP = cycles(FCLK, 1000000, GAP_US);
  localparam int C_TMO = cycles(FCLK, 1000, TIMEOUT_MS);
  localparam int TW    = cnt_width(max_i(C_TMO, C_GAP));

  state_e        state_q;
  logic [3:0]    btns_prev_q;
  logic [TW-1:0] timer_q;
  logic          valid_q, drop_q, err_q;
  logic [1:0]    code_q, mode_q;
  logic [3:0]    rise;
  logic [1:0]    push_code, head;
  logic          push, pop, fifo_empty, fifo_full;

  assign rise      = i_btns_deb & ~btns_prev_q;
  assign push      = |rise;
  // Simultaneous rises collapse onto the lowest button index.
  assign push_code = rise[0] ? CMD_BTN0 : rise[1] ? CMD_BTN1 : rise[2] ? CMD_BTN2 : CMD_BTN3;
  assign pop       = (state_q == ST_IDLE) & ~fifo_empty;

  cmd_fifo #(.W(2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk_mhz),
    .i_rst_n (i_rst_mhz_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_din   (push_code),
    .o_dout  (head),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  always_ff @(posedge i_clk_mhz or negedge i_rst_mhz_n) begin
    if (!i_rst_mhz_n) begin
      state_q     <= ST_IDLE;
      btns_prev_q <= '0;
      timer_q     <= '0;
      valid_q     <= 1'b0;
      code_q      <= '0;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
      mode_q      <= '0;
    end else begin
      btns_prev_q <= i_btns_deb;
      drop_q      <= push & fifo_full & ~pop;
      case (state_q)
        ST_IDLE: if (!fifo_empty) begin
          code_q  <= head;
          valid_q <= 1'b1;
          state_q <= ST_ISSUE;
        end
        ST_ISSUE: if (i_cmd_ready) begin
          valid_q <= 1'b0;
          timer_q <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: if (i_cmd_done) begin
          mode_q  <= code_q;
          timer_q <= '0;
          state_q <= ST_GAP;
        end else if (timer_q == TW'(C_TMO - 1)) begin
          err_q   <= 1'b1;
          timer_q <= '0;
          state_q <= ST_GAP;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
        ST_GAP: if (timer_q == TW'(C_GAP - 1)) begin
          timer_q <= '0;
          state_q <= ST_IDLE;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_valid   = valid_q;
  assign o_cmd_code    = code_q;
  assign o_busy        = (state_q != ST_IDLE) | ~fifo_empty;
  assign o_drop_pulse  = drop_q;
  assign o_err_timeout = err_q;
  assign o_mode        = mode_q;

endmodule

// File: tb/tb_btn_cmd_scheduler.sv
// tb_btn_cmd_scheduler: scenario tasks with an expected-command queue filled at each press and drained at each issue.
module tb_btn_cmd_scheduler;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [3:0] btns = 4'b0;
  logic       ready = 1'b0, done = 1'b0;
  logic       valid, busy, drop, err;
  logic [1:0] code, mode;
  int         vectors = 0, miscompares = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_code, exp_mode = 2'd0;

  always #5 clk = ~clk;

  btn_cmd_scheduler #(.FCLK(1000000), .FIFO_DEPTH(4), .GAP_US(10), .TIMEOUT_MS(1)) dut (
    .i_clk_mhz     (clk),
    .i_rst_mhz_n   (rst_n),
    .i_btns_deb    (btns),
    .o_cmd_valid   (valid),
    .o_cmd_code    (code),
    .i_cmd_ready   (ready),
    .i_cmd_done    (done),
    .o_busy        (busy),
    .o_drop_pulse  (drop),
    .o_err_timeout (err),
    .o_mode        (mode)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic logic [1:0] next_exp();
    return (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
  endfunction

  task automatic test_reset();
    repeat (3) tick();
    vectors++;
    if ({valid, code, busy, drop, err, mode} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, expected 00000000", {valid, code, busy, drop, err, mode});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    ready = 1'b1;
    btns = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL single_n1_valid: got %b, expected 0", valid); end
    tick();
    exp_code = next_exp();
    vectors++;
    if (valid !== 1'b1 || code !== exp_code) begin
      miscompares++;
      $display("FAIL single_n2_issue: got valid=%b code=%0d, expected valid=1 code=%0d", valid, code, exp_code);
    end
    btns = 4'b0000;
    tick();
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL single_n3_valid: got %b, expected 0", valid); end
    repeat (4) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    exp_mode = exp_code;
    vectors++;
    if (mode !== exp_mode) begin miscompares++; $display("FAIL single_mode: got %0d, expected %0d", mode, exp_mode); end
    repeat (9) tick();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL single_gap_busy: got %b, expected 1", busy); end
    tick();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad = 0;
    ready = 1'b0;
    btns = 4'b0001;
    exp_q.push_back(2'd0);
    tick();
    btns = 4'b0000;
    wait_valid(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bp_valid_wait: got no valid, expected valid"); end
    exp_code = next_exp();
    for (int i = 0; i < 20; i++) begin
      if (valid !== 1'b1 || code !== exp_code) bad++;
      if (i == 5) done = 1'b1;
      tick();
      done = 1'b0;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL bp_hold: got %0d unstable cycles, expected 0", bad); end
    vectors++;
    if (valid !== 1'b1 || code !== exp_code) begin
      miscompares++;
      $display("FAIL bp_still_valid: got valid=%b code=%0d, expected valid=1 code=%0d", valid, code, exp_code);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL bp_after_hs: got %b, expected 0", valid); end
    tick();
    vectors++;
    if (valid !== 1'b0 || mode !== exp_mode) begin
      miscompares++;
      $display("FAIL bp_one_hs: got valid=%b mode=%0d, expected valid=0 mode=%0d", valid, mode, exp_mode);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    exp_mode = exp_code;
    vectors++;
    if (mode !== exp_mode) begin miscompares++; $display("FAIL bp_mode: got %0d, expected %0d", mode, exp_mode); end
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bp_idle: got busy, expected idle"); end
  endtask

  task automatic test_overflow();
    logic [1:0] codes [6] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    int drops = 0, drop_idx = -1;
    bit ok;
    ready = 1'b0;
    for (int p = 0; p < 6; p++) begin
      btns = 4'b0001 << codes[p];
      if (p < 5) exp_q.push_back(codes[p]);
      tick();
      if (drop === 1'b1) begin drops++; drop_idx = p; end
      btns = 4'b0000;
      tick();
      if (drop === 1'b1) drops++;
      tick();
      if (drop === 1'b1) drops++;
    end
    vectors++;
    if (drops != 1) begin miscompares++; $display("FAIL ovf_drop_count: got %0d, expected 1", drops); end
    vectors++;
    if (drop_idx != 5) begin miscompares++; $display("FAIL ovf_drop_press: got %0d, expected 5", drop_idx); end
    ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_valid(ok);
      exp_code = next_exp();
      vectors++;
      if (!ok || code !== exp_code) begin
        miscompares++;
        $display("FAIL ovf_order_%0d: got valid=%b code=%0d, expected valid=1 code=%0d", k, valid, code, exp_code);
      end
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      exp_mode = exp_code;
      vectors++;
      if (mode !== exp_mode) begin miscompares++; $display("FAIL ovf_mode_%0d: got %0d, expected %0d", k, mode, exp_mode); end
    end
    wait_idle(ok);
    ok = ok && (valid === 1'b0);
    repeat (5) begin tick(); if (valid !== 1'b0) ok = 1'b0; end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL ovf_no_extra: got extra activity, expected idle"); end
  endtask

  task automatic test_timeout();
    bit ok;
    ready = 1'b1;
    btns = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    btns = 4'b1100;
    exp_q.push_back(2'd3);
    tick();
    exp_code = next_exp();
    vectors++;
    if (valid !== 1'b1 || code !== exp_code) begin
      miscompares++;
      $display("FAIL tmo_issue: got valid=%b code=%0d, expected valid=1 code=%0d", valid, code, exp_code);
    end
    tick();
    btns = 4'b0000;
    repeat (999) tick();
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL tmo_early: got %b, expected 0", err); end
    tick();
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL tmo_flag: got %b, expected 1", err); end
    vectors++;
    if (mode !== exp_mode) begin miscompares++; $display("FAIL tmo_mode: got %0d, expected %0d", mode, exp_mode); end
    repeat (10) tick();
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL tmo_gap_valid: got %b, expected 0", valid); end
    tick();
    exp_code = next_exp();
    vectors++;
    if (valid !== 1'b1 || code !== exp_code) begin
      miscompares++;
      $display("FAIL tmo_next_issue: got valid=%b code=%0d, expected valid=1 code=%0d", valid, code, exp_code);
    end
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    exp_mode = exp_code;
    vectors++;
    if (mode !== exp_mode || err !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_sticky: got mode=%0d err=%b, expected mode=%0d err=1", mode, err, exp_mode);
    end
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL tmo_idle: got busy, expected idle"); end
  endtask

  task automatic test_simul();
    bit ok, seen = 1'b0, dropped = 1'b0;
    ready = 1'b1;
    btns = 4'b1010;
    exp_q.push_back(2'd1);
    tick();
    if (drop !== 1'b0) dropped = 1'b1;
    btns = 4'b0000;
    wait_valid(ok);
    exp_code = next_exp();
    vectors++;
    if (!ok || code !== exp_code) begin
      miscompares++;
      $display("FAIL simul_code: got valid=%b code=%0d, expected valid=1 code=%0d", valid, code, exp_code);
    end
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    exp_mode = exp_code;
    vectors++;
    if (mode !== exp_mode) begin miscompares++; $display("FAIL simul_mode: got %0d, expected %0d", mode, exp_mode); end
    wait_idle(ok);
    repeat (5) begin tick(); if (valid !== 1'b0) seen = 1'b1; if (drop !== 1'b0) dropped = 1'b1; end
    vectors++;
    if (!ok || seen || dropped) begin
      miscompares++;
      $display("FAIL simul_single: got idle=%b extra=%b drop=%b, expected idle=1 extra=0 drop=0", ok, seen, dropped);
    end
  endtask

  task automatic test_async_reset();
    bit ok, seen = 1'b0;
    ready = 1'b1;
    btns = 4'b0001;
    exp_q.push_back(2'd0);
    tick();
    btns = 4'b0000;
    wait_valid(ok);
    exp_code = next_exp();
    vectors++;
    if (!ok || code !== exp_code) begin
      miscompares++;
      $display("FAIL ar_first: got valid=%b code=%0d, expected valid=1 code=%0d", valid, code, exp_code);
    end
    tick();
    btns = 4'b0010; exp_q.push_back(2'd1); tick();
    btns = 4'b0000; tick();
    btns = 4'b1000; exp_q.push_back(2'd3); tick();
    btns = 4'b0000; tick();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL ar_busy_before: got %b, expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({valid, code, busy, drop, err, mode} !== 8'h00) begin
      miscompares++;
      $display("FAIL ar_immediate: got %b, expected 00000000", {valid, code, busy, drop, err, mode});
    end
    exp_q.delete();
    exp_mode = 2'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    btns = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    btns = 4'b0000;
    wait_valid(ok);
    exp_code = next_exp();
    vectors++;
    if (!ok || code !== exp_code) begin
      miscompares++;
      $display("FAIL ar_post_issue: got valid=%b code=%0d, expected valid=1 code=%0d", valid, code, exp_code);
    end
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    exp_mode = exp_code;
    vectors++;
    if (mode !== exp_mode) begin miscompares++; $display("FAIL ar_post_mode: got %0d, expected %0d", mode, exp_mode); end
    wait_idle(ok);
    repeat (20) begin tick(); if (valid !== 1'b0) seen = 1'b1; end
    vectors++;
    if (!ok || seen) begin
      miscompares++;
      $display("FAIL ar_no_stale: got idle=%b extra=%b, expected idle=1 extra=0", ok, seen);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_timeout();
    test_simul();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
